lcd_bus_responder: RTL and testbench

- Target side of the 8080-style parallel LCD bus (cs/wr/rd/rs/d, all active-low strobes except rs) that our LCD controller drives.
- Samples the host's write strobes and forwards each command and parameter byte as an event into a small FIFO.
- Tracks display state from decoded commands and answers host read cycles for the ID/status commands.
- Used as an on-FPGA panel model in loopback tests, and as the receiving end when another board drives us as a panel.

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_event_fifo.sv | 64 ++++++
 rtl/lcd_bus_responder.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus responder.
// Latency: none; declarations and a combinational reply helper only.
// Backpressure: none; nothing here handles flow control.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_RDDID   = 8'h04;
    localparam logic [7:0] CMD_RDDST   = 8'h09;
    localparam logic [7:0] CMD_RDDPM   = 8'h0A;

    localparam int EV_W = 17;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DRIVE = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_t;

    // One captured bus write: command flag, byte, parameter index.
    typedef struct packed {
        logic       is_cmd;
        logic [7:0] data;
        logic [7:0] idx;
    } ev_t;

    // Byte returned on read number n after the given command (n = 0 is the dummy).
    function automatic logic [7:0] reply_byte(
        input logic [7:0]  cmd,
        input logic [7:0]  n,
        input logic        disp,
        input logic        slp,
        input logic [23:0] id
    );
        logic [7:0] r;
        r = 8'h00;
        case (cmd)
            CMD_RDDID: begin
                case (n)
                    8'd1:    r = id[23:16];
                    8'd2:    r = id[15:8];
                    8'd3:    r = id[7:0];
                    default: r = 8'h00;
                endcase
            end
            CMD_RDDST: r = (n == 8'd1) ? {disp, slp, 6'b0} : 8'h00;
            CMD_RDDPM: r = (n == 8'd1) ? {1'b0, slp, 2'b0, disp, 3'b0} : 8'h00;
            default:   r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_event_fifo.sv
// Synchronous event FIFO, DEPTH x 17 bits, head read straight from registers.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module lcd_event_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  ev_t  push_dat,
    input  logic pop,
    output ev_t  head,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    ev_t           mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // Pointer, occupancy and storage update; clr empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// Panel-side 8080 bus target: captures writes as FIFO events, tracks display flags, answers ID/status reads.
// Latency: write to ev_valid is SYNC_STAGES+2 clk; read drive starts SYNC_STAGES+1 clk after rd falls.
// Backpressure: ev_ready stalls the FIFO; writes arriving while full are dropped and flagged in ev_overflow.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [23:0] PANEL_ID    = 24'h009341
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_cs_n,
    input  logic       bus_wr_n,
    input  logic       bus_rd_n,
    input  logic       bus_rs,
    input  logic       bus_rst_n,
    input  logic [7:0] bus_d_i,
    output logic [7:0] bus_d_o,
    output logic       bus_d_oe,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_is_cmd,
    output logic [7:0] ev_data,
    output logic [7:0] ev_idx,
    output logic       ev_overflow,
    output logic       display_on,
    output logic       sleep_out
);

    // Synchronizer lanes: {rst_n, cs_n, wr_n, rd_n, rs, d[7:0]}.
    // Strobes reset to their idle level so leaving reset never looks like an edge.
    localparam logic [12:0] SYNC_IDLE = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    logic [12:0] sync_q [SYNC_STAGES];
    logic [12:0] sync_out;
    logic        rst_s, cs_s, wr_s, rd_s, rs_s;
    logic [7:0]  d_s;
    logic        soft_rst;
    logic        wr_prev, rd_prev;
    logic        wr_rise, rd_fall;

    logic        cap_vld, cap_is_cmd;
    logic [7:0]  cap_data;
    logic [7:0]  param_cnt, idx_next;
    logic [7:0]  last_cmd;
    ev_t         ev_in, fifo_head;
    logic        fifo_full, fifo_empty;
    logic        push, pop, drop, cmd_wr;

    rd_state_t   rd_state;
    logic [7:0]  rd_cnt;
    logic        rd_exit;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rst_s    = sync_out[12];
    assign cs_s     = sync_out[11];
    assign wr_s     = sync_out[10];
    assign rd_s     = sync_out[9];
    assign rs_s     = sync_out[8];
    assign d_s      = sync_out[7:0];
    assign soft_rst = ~rst_s;

    // Data shares the strobe depth so the byte is aligned with the wr edge that carries it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
        end else begin
            sync_q[0] <= {bus_rst_n, bus_cs_n, bus_wr_n, bus_rd_n, bus_rs, bus_d_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Previous strobe levels for edge detection; they keep tracking through soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
        end else begin
            wr_prev <= wr_s;
            rd_prev <= rd_s;
        end
    end

    assign wr_rise = wr_s & ~wr_prev & ~cs_s;
    // A read only starts when wr is idle: a simultaneous write wins.
    assign rd_fall = ~rd_s & rd_prev & ~cs_s & rs_s & wr_s;

    // Register the detected write so the FIFO push lands one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld    <= 1'b0;
            cap_is_cmd <= 1'b0;
            cap_data   <= 8'h00;
        end else if (soft_rst) begin
            cap_vld    <= 1'b0;
            cap_is_cmd <= 1'b0;
            cap_data   <= 8'h00;
        end else begin
            cap_vld    <= wr_rise;
            cap_is_cmd <= ~rs_s;
            cap_data   <= d_s;
        end
    end

    assign idx_next     = (param_cnt == 8'hFF) ? 8'hFF : param_cnt + 8'd1;
    assign ev_in.is_cmd = cap_is_cmd;
    assign ev_in.data   = cap_data;
    assign ev_in.idx    = cap_is_cmd ? 8'h00 : idx_next;

    assign push   = cap_vld & ~soft_rst;
    assign pop    = ev_ready;
    assign drop   = push & fifo_full & ~(ev_ready & ~fifo_empty);
    assign cmd_wr = push & cap_is_cmd;

    lcd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (soft_rst),
        .push     (push),
        .push_dat (ev_in),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ev_valid  = ~fifo_empty;
    assign ev_is_cmd = fifo_head.is_cmd;
    assign ev_data   = fifo_head.data;
    assign ev_idx    = fifo_head.idx;

    // Command decode: parameter counter, display flags, last command; flags update even if the event drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            param_cnt   <= 8'h00;
            last_cmd    <= 8'h00;
            display_on  <= 1'b0;
            sleep_out   <= 1'b0;
            ev_overflow <= 1'b0;
        end else begin
            if (drop) begin
                ev_overflow <= 1'b1;
            end
            if (soft_rst) begin
                param_cnt  <= 8'h00;
                last_cmd   <= 8'h00;
                display_on <= 1'b0;
                sleep_out  <= 1'b0;
            end else if (push) begin
                if (cap_is_cmd) begin
                    param_cnt <= 8'h00;
                    last_cmd  <= cap_data;
                    case (cap_data)
                        CMD_DISPON:  display_on <= 1'b1;
                        CMD_DISPOFF: display_on <= 1'b0;
                        CMD_SLPOUT:  sleep_out  <= 1'b1;
                        CMD_SLPIN:   sleep_out  <= 1'b0;
                        default:     ;
                    endcase
                end else begin
                    param_cnt <= idx_next;
                end
            end
        end
    end

    assign rd_exit = rd_s | cs_s;

    // Read FSM: drive the reply byte while rd is low, release and advance the byte counter on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= 8'h00;
            bus_d_o  <= 8'h00;
            bus_d_oe <= 1'b0;
        end else if (soft_rst) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= 8'h00;
            bus_d_o  <= 8'h00;
            bus_d_oe <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (rd_fall) begin
                        rd_state <= RD_DRIVE;
                        bus_d_o  <= reply_byte(last_cmd, rd_cnt, display_on, sleep_out, PANEL_ID);
                        bus_d_oe <= 1'b1;
                    end
                end
                RD_DRIVE, RD_HOLD: begin
                    if (rd_exit) begin
                        rd_state <= RD_IDLE;
                        bus_d_oe <= 1'b0;
                        rd_cnt   <= (rd_cnt == 8'hFF) ? 8'hFF : rd_cnt + 8'd1;
                    end else begin
                        rd_state <= RD_HOLD;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    bus_d_oe <= 1'b0;
                end
            endcase
            if (cmd_wr) begin
                rd_cnt <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: write capture, FIFO overflow, read replies, resets.
// Latency: checks event arrival at SYNC_STAGES+2 clk after the wr rising edge.
// Backpressure: drives ev_ready low to fill the FIFO, then drains it.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_cs_n, bus_wr_n, bus_rd_n, bus_rs, bus_rst_n;
    logic [7:0] bus_d_i;
    logic [7:0] bus_d_o;
    logic       bus_d_oe;
    logic       ev_valid, ev_ready, ev_is_cmd, ev_overflow, display_on, sleep_out;
    logic [7:0] ev_data, ev_idx;

    int checks = 0;
    int errors = 0;

    lcd_bus_responder #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4),
        .PANEL_ID    (24'h009341)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_cs_n    (bus_cs_n),
        .bus_wr_n    (bus_wr_n),
        .bus_rd_n    (bus_rd_n),
        .bus_rs      (bus_rs),
        .bus_rst_n   (bus_rst_n),
        .bus_d_i     (bus_d_i),
        .bus_d_o     (bus_d_o),
        .bus_d_oe    (bus_d_oe),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_is_cmd   (ev_is_cmd),
        .ev_data     (ev_data),
        .ev_idx      (ev_idx),
        .ev_overflow (ev_overflow),
        .display_on  (display_on),
        .sleep_out   (sleep_out)
    );

    always #5 clk = ~clk;

    // Host write cycle: wr low 4 clk, data held 4 clk after the rising edge.
    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(posedge clk); #2;
        bus_cs_n = 1'b0; bus_rs = rs; bus_d_i = d; bus_wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus_wr_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 bus_cs_n = 1'b1;
    endtask

    // Host read cycle: returns bus state before, during and after rd low.
    task automatic bus_read(output logic [7:0] dat, output logic oe_before,
                            output logic oe_mid, output logic oe_after);
        @(posedge clk); #2;
        oe_before = bus_d_oe;
        bus_cs_n = 1'b0; bus_rs = 1'b1; bus_rd_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 dat = bus_d_o; oe_mid = bus_d_oe;
        #1 bus_rd_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 oe_after = bus_d_oe;
        #1 bus_cs_n = 1'b1;
    endtask

    // Wait (bounded) for a head event, capture it and pop it.
    task automatic pop_head(output logic is_cmd, output logic [7:0] data,
                            output logic [7:0] idx, output logic ok);
        int n;
        ok = 1'b0; is_cmd = 1'b0; data = 8'h00; idx = 8'h00;
        n = 0;
        while (!ev_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (ev_valid) begin
            ok = 1'b1;
            is_cmd = ev_is_cmd; data = ev_data; idx = ev_idx;
            ev_ready = 1'b1;
            @(posedge clk); #1;
            ev_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_cs_n = 1'b1; bus_wr_n = 1'b1; bus_rd_n = 1'b1;
        bus_rs = 1'b0; bus_rst_n = 1'b1; bus_d_i = 8'h00; ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_d_o, bus_d_oe, ev_valid, ev_overflow, display_on, sleep_out} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got d_o=%h oe=%b vld=%b ovf=%b don=%b slp=%b want all 0",
                     bus_d_o, bus_d_oe, ev_valid, ev_overflow, display_on, sleep_out);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ev_valid !== 1'b0 || bus_d_oe !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got vld=%b oe=%b want 0 0", ev_valid, bus_d_oe);
        end
    endtask

    task automatic test_cmd_timing();
        logic c, ok; logic [7:0] d, i;
        @(posedge clk); #2;
        bus_cs_n = 1'b0; bus_rs = 1'b0; bus_d_i = 8'h29; bus_wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus_wr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ev_valid !== 1'b0 || display_on !== 1'b0) begin
            errors++;
            $display("FAIL dispon_early got vld=%b don=%b want 0 0 at 3 clk", ev_valid, display_on);
        end
        @(posedge clk); #1;
        checks++;
        if (ev_valid !== 1'b1 || display_on !== 1'b1) begin
            errors++;
            $display("FAIL dispon_latency got vld=%b don=%b want 1 1 at 4 clk", ev_valid, display_on);
        end
        #1 bus_cs_n = 1'b1;
        pop_head(c, d, i, ok);
        checks++;
        if (!ok || {c, d, i} !== {1'b1, 8'h29, 8'h00}) begin
            errors++;
            $display("FAIL dispon_event got ok=%b cmd=%b d=%h idx=%h want 1 1 29 00", ok, c, d, i);
        end
    endtask

    task automatic test_params();
        logic       exp_c [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_d [5] = '{8'h2A, 8'h00, 8'h10, 8'h00, 8'hEF};
        logic c, ok; logic [7:0] d, i;
        for (int k = 0; k < 5; k++) begin
            bus_write(~exp_c[k], exp_d[k]);
            pop_head(c, d, i, ok);
            checks++;
            if (!ok || c !== exp_c[k] || d !== exp_d[k] || i !== 8'(k)) begin
                errors++;
                $display("FAIL param_event%0d got ok=%b cmd=%b d=%h idx=%h want 1 %b %h %h",
                         k, ok, c, d, i, exp_c[k], exp_d[k], 8'(k));
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d [4] = '{8'h2C, 8'hA1, 8'hA2, 8'hA3};
        logic c, ok; logic [7:0] d, i;
        ev_ready = 1'b0;
        checks++;
        if (ev_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got %b want 0", ev_overflow);
        end
        bus_write(1'b0, 8'h2C);
        for (int k = 1; k <= 5; k++) bus_write(1'b1, 8'hA0 + 8'(k));
        #1;
        checks++;
        if (ev_overflow !== 1'b1 || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b vld=%b want 1 1", ev_overflow, ev_valid);
        end
        for (int k = 0; k < 4; k++) begin
            pop_head(c, d, i, ok);
            checks++;
            if (!ok || c !== (k == 0) || d !== exp_d[k] || i !== 8'(k)) begin
                errors++;
                $display("FAIL ovf_drain%0d got ok=%b cmd=%b d=%h idx=%h want 1 %b %h %h",
                         k, ok, c, d, i, (k == 0), exp_d[k], 8'(k));
            end
        end
        checks++;
        if (ev_valid !== 1'b0 || ev_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got vld=%b ovf=%b want 0 1", ev_valid, ev_overflow);
        end
    endtask

    task automatic test_rddid();
        logic [7:0] exp_r [4] = '{8'h00, 8'h00, 8'h93, 8'h41};
        logic [7:0] r; logic ob, om, oa;
        ev_ready = 1'b1;
        bus_write(1'b0, 8'h04);
        for (int k = 0; k < 4; k++) begin
            bus_read(r, ob, om, oa);
            checks++;
            if (r !== exp_r[k] || ob !== 1'b0 || om !== 1'b1 || oa !== 1'b0) begin
                errors++;
                $display("FAIL rddid_read%0d got d=%h oe=%b/%b/%b want %h 0/1/0",
                         k, r, ob, om, oa, exp_r[k]);
            end
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_rddst_softrst();
        logic [7:0] r; logic ob, om, oa;
        ev_ready = 1'b1;
        bus_write(1'b0, 8'h11);
        bus_write(1'b0, 8'h29);
        bus_write(1'b0, 8'h09);
        checks++;
        if (sleep_out !== 1'b1 || display_on !== 1'b1) begin
            errors++;
            $display("FAIL flags_set got slp=%b don=%b want 1 1", sleep_out, display_on);
        end
        bus_read(r, ob, om, oa);
        checks++;
        if (r !== 8'h00 || om !== 1'b1) begin
            errors++;
            $display("FAIL rddst_dummy got d=%h oe=%b want 00 1", r, om);
        end
        bus_read(r, ob, om, oa);
        checks++;
        if (r !== 8'hC0 || om !== 1'b1) begin
            errors++;
            $display("FAIL rddst_status got d=%h oe=%b want c0 1", r, om);
        end
        ev_ready = 1'b0;
        bus_write(1'b0, 8'h2C);
        @(posedge clk); #2 bus_rst_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({display_on, sleep_out, ev_valid, ev_overflow} !== 4'b0001) begin
            errors++;
            $display("FAIL soft_reset got don=%b slp=%b vld=%b ovf=%b want 0 0 0 1",
                     display_on, sleep_out, ev_valid, ev_overflow);
        end
        #1 bus_rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_rddpm();
        logic [7:0] r; logic ob, om, oa;
        ev_ready = 1'b1;
        bus_write(1'b0, 8'h29);
        bus_write(1'b0, 8'h0A);
        bus_read(r, ob, om, oa);
        bus_read(r, ob, om, oa);
        checks++;
        if (r !== 8'h08 || om !== 1'b1) begin
            errors++;
            $display("FAIL rddpm_status got d=%h oe=%b want 08 1", r, om);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_wr_priority();
        logic c, ok, oe_mid; logic [7:0] d, i;
        @(posedge clk); #2;
        bus_cs_n = 1'b0; bus_rs = 1'b1; bus_d_i = 8'h5A; bus_wr_n = 1'b0; bus_rd_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 oe_mid = bus_d_oe;
        #1 bus_wr_n = 1'b1; bus_rd_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 bus_cs_n = 1'b1;
        checks++;
        if (oe_mid !== 1'b0 || bus_d_oe !== 1'b0) begin
            errors++;
            $display("FAIL wr_priority_oe got %b/%b want 0/0", oe_mid, bus_d_oe);
        end
        pop_head(c, d, i, ok);
        checks++;
        if (!ok || {c, d, i} !== {1'b0, 8'h5A, 8'h01}) begin
            errors++;
            $display("FAIL wr_priority_event got ok=%b cmd=%b d=%h idx=%h want 1 0 5a 01", ok, c, d, i);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] r; logic ob, om, oa;
        ev_ready = 1'b1;
        bus_write(1'b0, 8'h04);
        bus_read(r, ob, om, oa);
        bus_read(r, ob, om, oa);
        @(posedge clk); #2;
        bus_cs_n = 1'b0; bus_rs = 1'b1; bus_rd_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus_d_oe !== 1'b1 || bus_d_o !== 8'h93 || display_on !== 1'b1) begin
            errors++;
            $display("FAIL midread_drive got oe=%b d=%h don=%b want 1 93 1", bus_d_oe, bus_d_o, display_on);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_d_o, bus_d_oe, ev_valid, ev_overflow, display_on, sleep_out} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset got d_o=%h oe=%b vld=%b ovf=%b don=%b slp=%b want all 0",
                     bus_d_o, bus_d_oe, ev_valid, ev_overflow, display_on, sleep_out);
        end
        bus_rd_n = 1'b1; bus_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus_d_oe !== 1'b0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got oe=%b vld=%b want 0 0", bus_d_oe, ev_valid);
        end
        ev_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cmd_timing();
        test_params();
        test_overflow();
        test_rddid();
        test_rddst_softrst();
        test_rddpm();
        test_wr_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
